// File: rtl/behav_sweep_checker.sv
// -----------------------------------------------------------------------------
// behav_sweep_checker
//   Stimulus/response stage for the behav function unit F = (AB' + A'B)(C + D').
//   On start it steps all 16 {A,B,C,D} vectors in ascending order. Each vector
//   is held for HOLD_CYCLES clocks. The unit's F output is sampled in the last
//   hold cycle and compared against a built-in golden model. The stage counts
//   mismatches (saturating), captures the first failing vector, and reports
//   done/pass when the sweep ends.
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous reset, active-high
//   start           in   single-cycle sweep request, honoured in IDLE or DONE
//   f_in            in   F output of the unit under check
//   vec_out         out  applied vector {A,B,C,D}
//   exp_f           out  golden F for vec_out (combinational)
//   busy            out  high while sweeping
//   done            out  high once the sweep finished, until the next start
//   pass            out  valid with done; high when no mismatch was seen
//   err_cnt         out  saturating mismatch count of current/last sweep
//   first_err_vec   out  vector at the first mismatch
//   first_err_valid out  first_err_vec holds a captured value
// -----------------------------------------------------------------------------
module behav_sweep_checker #(
    parameter int HOLD_CYCLES = 10,
    parameter int ERR_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             f_in,
    output logic [3:0]       vec_out,
    output logic             exp_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       first_err_vec,
    output logic             first_err_valid
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_vec;
    logic [HW-1:0]    r_hold;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [3:0]       r_fvec;
    logic             r_fvalid;

    logic             w_start_ok;
    logic             w_sample;
    logic             w_exp;
    logic             w_mis;
    logic [ERR_W-1:0] w_err_next;

    // Golden model: (A xor B) and (C or not D).
    assign w_exp      = (r_vec[3] ^ r_vec[2]) & (r_vec[1] | ~r_vec[0]);
    assign w_start_ok = start && (r_state != S_RUN);
    assign w_sample   = (r_state == S_RUN) && (r_hold == HOLD_LAST);
    assign w_mis      = w_sample && (f_in != w_exp);
    // Counter saturates at all-ones instead of wrapping.
    assign w_err_next = (w_mis && (r_err != {ERR_W{1'b1}})) ? r_err + 1'b1 : r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_sample && (r_vec == 4'hF)) w_next = S_DONE;
            S_DONE:  if (start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec    <= 4'h0;
            r_hold   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_fvec   <= 4'h0;
            r_fvalid <= 1'b0;
        end else if (w_start_ok) begin
            r_vec    <= 4'h0;
            r_hold   <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_fvec   <= 4'h0;
            r_fvalid <= 1'b0;
        end else if (w_sample) begin
            r_err <= w_err_next;
            if (w_mis && !r_fvalid) begin
                r_fvec   <= r_vec;
                r_fvalid <= 1'b1;
            end
            if (r_vec == 4'hF) begin
                // Last vector: its own mismatch is folded into pass.
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (w_err_next == '0);
            end else begin
                r_vec  <= r_vec + 1'b1;
                r_hold <= '0;
            end
        end else if (r_state == S_RUN) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    assign vec_out         = r_vec;
    assign exp_f           = w_exp;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_cnt         = r_err;
    assign first_err_vec   = r_fvec;
    assign first_err_valid = r_fvalid;

endmodule

// File: tb/tb_behav_sweep_checker.sv
module tb_behav_sweep_checker;

    localparam int HOLD = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] tt = 16'h0000;

    logic        f_in, f_in2;
    logic [3:0]  vec_out, vec_out2;
    logic        exp_f, exp_f2;
    logic        busy, busy2, done, done2, pass, pass2;
    logic [4:0]  err_cnt;
    logic [1:0]  err_cnt2;
    logic [3:0]  fvec, fvec2;
    logic        fvalid, fvalid2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // The "unit under check" is a truth table indexed by the applied vector.
    assign f_in  = tt[vec_out];
    assign f_in2 = tt[vec_out2];

    behav_sweep_checker #(.HOLD_CYCLES(HOLD), .ERR_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .f_in(f_in),
        .vec_out(vec_out), .exp_f(exp_f), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_vec(fvec), .first_err_valid(fvalid)
    );

    behav_sweep_checker #(.HOLD_CYCLES(HOLD), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .f_in(f_in2),
        .vec_out(vec_out2), .exp_f(exp_f2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err_cnt2), .first_err_vec(fvec2), .first_err_valid(fvalid2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // F straight from the boolean definition on the decoded literals.
    function automatic int golden(input int v);
        int a, b, c, d;
        a = v / 8; b = (v / 4) % 2; c = (v / 2) % 2; d = v % 2;
        return ((a != b) && (c == 1 || d == 0)) ? 1 : 0;
    endfunction

    // Outcome of a sweep over truth table t, from the rules alone.
    task automatic model(input logic [15:0] t, output int cnt, output int fv, output int fval);
        cnt = 0; fv = 0; fval = 0;
        for (int v = 0; v < 16; v++) begin
            if (int'(t[v]) != golden(v)) begin
                cnt++;
                if (fval == 0) begin fv = v; fval = 1; end
            end
        end
    endtask

    // Runs one sweep; returns cycles from start edge to done (-1 on timeout).
    task automatic run_sweep(input logic [15:0] t, input bit extra_starts, output int lat);
        int vec_bad, exp_bad;
        vec_bad = 0; exp_bad = 0; lat = -1;
        tt = t;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (vec_out != 4'h0 || busy !== 1'b1 || done !== 1'b0) vec_bad++;
        for (int k = 1; k <= 16 * HOLD + 40; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin lat = k; break; end
            if (int'(vec_out) != k / HOLD || busy !== 1'b1) vec_bad++;
            if (int'(exp_f) != golden(int'(vec_out))) exp_bad++;
            if (extra_starts && (k == 37 || k == 99 || k == 155)) start = 1'b1;
        end
        chk("vec_step_errors", vec_bad, 0);
        chk("exp_f_errors", exp_bad, 0);
        if (lat < 0) $display("FAIL done_timeout: done never rose, needed at cycle %0d", 16 * HOLD);
        chk("done_latency", lat, 16 * HOLD);
    endtask

    task automatic check_results(input int e_err, input int e_fvec, input int e_fval);
        int e_sat;
        e_sat = (e_err > 3) ? 3 : e_err;
        chk("busy_after_done", int'(busy), 0);
        chk("vec_at_done", int'(vec_out), 15);
        chk("err_cnt", int'(err_cnt), e_err);
        chk("first_err_valid", int'(fvalid), e_fval);
        chk("first_err_vec", int'(fvec), e_fvec);
        chk("pass", int'(pass), (e_err == 0) ? 1 : 0);
        chk("err_cnt_w2_sat", int'(err_cnt2), e_sat);
        chk("done_w2", int'(done2), 1);
    endtask

    typedef struct {
        logic [15:0] tt;
        bit          extra;
        int          err;
        int          fvec;
        int          fval;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int lat, m_cnt, m_fv, m_fval, cyc;
        logic [15:0] rt;

        // Truth tables with hand-derived outcomes (correct F = ones at 4,6,7,8,10,11).
        tbl[0] = '{16'h0DD0, 1'b0,  0, 0, 0};   // correct unit
        tbl[1] = '{16'h0000, 1'b0,  6, 4, 1};   // stuck at 0
        tbl[2] = '{16'hFFFF, 1'b0, 10, 0, 1};   // stuck at 1
        tbl[3] = '{16'h8DD0, 1'b0,  1, 15, 1};  // only the last vector wrong
        tbl[4] = '{16'h0DD1, 1'b1,  1, 0, 1};   // first vector wrong, extra starts while busy
        tbl[5] = '{16'h0DD0, 1'b1,  0, 0, 0};   // correct unit, extra starts while busy

        // Reset held 3 cycles, then released.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_vec", int'(vec_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_fvec", int'(fvec), 0);
        chk("rst_fvalid", int'(fvalid), 0);
        repeat (5) @(posedge clk);
        #1 chk("idle_no_start_busy", int'(busy), 0);

        // Table sweeps; each after the first starts from DONE.
        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i].tt, tbl[i].extra, lat);
            check_results(tbl[i].err, tbl[i].fvec, tbl[i].fval);
        end

        // DONE holds its results without a new start.
        repeat (7) @(posedge clk);
        #1;
        chk("done_hold", int'(done), 1);
        chk("done_hold_vec", int'(vec_out), 15);
        chk("done_hold_pass", int'(pass), 1);

        // Rerun from DONE with stuck-at-1: identical results to the first run.
        run_sweep(16'hFFFF, 1'b0, lat);
        check_results(10, 0, 1);

        // Random faulty units against the reference model.
        for (int r = 0; r < 8; r++) begin
            rt = 16'($urandom);
            model(rt, m_cnt, m_fv, m_fval);
            run_sweep(rt, r[0], lat);
            check_results(m_cnt, m_fv, m_fval);
        end

        // Mid-sweep asynchronous reset while vector 7 is applied.
        tt = 16'hFFFF;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (vec_out != 4'h7 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_vec7", int'(vec_out), 7);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_vec", int'(vec_out), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_err", int'(err_cnt), 0);
        chk("async_rst_fvalid", int'(fvalid), 0);
        chk("async_rst_done", int'(done), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("after_rst_idle_busy", int'(busy), 0);
        chk("after_rst_idle_vec", int'(vec_out), 0);

        // Clean full sweep after the abort.
        run_sweep(16'h0DD0, 1'b0, lat);
        check_results(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
